// File: rtl/passenger_pkg.sv
// passenger_pkg: shared constants, types and occupancy-bit
// index helpers for the passenger queue.
package passenger_pkg;
  localparam int N_FLOORS = 7;
  localparam int SLOTS = 2;
  localparam int FLOOR_W = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int OCC_W = N_FLOORS * SLOTS;
  localparam logic [FLOOR_W-1:0] EMPTY_FLOOR = 3'd0;

  localparam int HOLD_ALIGHT = 5;
  localparam int HOLD_DROP = 3;
  localparam int HOLD_BOARD = 2;
  localparam int HOLD_PICK = 0;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  typedef logic [SLOTS-1:0][FLOOR_W-1:0] pair_t;
  typedef pair_t [N_FLOORS-1:0] side_t;
  typedef side_t [1:0] hall_t;

  typedef struct packed {
    logic [FLOOR_W-1:0] src;
    logic [FLOOR_W-1:0] dst;
  } call_t;

  function automatic int up_bit(int f, int s);
    return 2 * (f - 1) + s;
  endfunction

  function automatic int dn_bit(int f, int s);
    return OCC_W - 1 - 2 * (f - 1) - (1 - s);
  endfunction

  function automatic logic floor_ok(
    logic [FLOOR_W-1:0] f
  );
    return (int'(f) >= 1) && (int'(f) <= N_FLOORS);
  endfunction
endpackage

// File: rtl/passenger_queue_if.sv
// passenger_queue_if: hall-call request handshake.
// master drives valid/src/dst; slave returns ready/err.
interface passenger_queue_if;
  import passenger_pkg::*;

  logic req_valid;
  logic [FLOOR_W-1:0] req_src;
  logic [FLOOR_W-1:0] req_dst;
  logic req_ready;
  logic req_err;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, req_err
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, req_err
  );
endinterface

// File: rtl/req_fifo.sv
// req_fifo: generic synchronous FIFO, show-ahead head.
// Ports: push/din in, pop/dout out, full/empty flags.
module req_fifo #(
  parameter int W = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;

  function automatic logic [AW-1:0] inc(
    logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop) rp <= inc(rp);
      if (do_push && !do_pop) cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/passenger_queue.sv
// passenger_queue: hall-call store, car boarding/alighting.
// Ports: clk, rst_n, req (call handshake), curr_elevator_1/2,
// dir_elevator, hold_1/2 in; up/down_passenger, boarding_1/2,
// waiting_cnt out. Optional request FIFO: PQ_REQ_FIFO_EN.
module passenger_queue
  import passenger_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  passenger_queue_if.slave   req,
  input  logic [FLOOR_W-1:0] curr_elevator_1,
  input  logic [FLOOR_W-1:0] curr_elevator_2,
  input  logic [1:0]         dir_elevator,
  input  logic [5:0]         hold_1,
  input  logic [5:0]         hold_2,
  output logic [OCC_W-1:0]   up_passenger,
  output logic [OCC_W-1:0]   down_passenger,
  output logic [5:0]         boarding_1,
  output logic [5:0]         boarding_2,
  output logic [4:0]         waiting_cnt
);
  hall_t hall_q, hall_d;
  pair_t [1:0] car_q, car_d;
  logic [4:0] cnt_q, cnt_d;
  logic err_q, err_d;

  call_t in_call, cand;
  logic cand_vld;

  assign in_call.src = req.req_src;
  assign in_call.dst = req.req_dst;

`ifdef PQ_REQ_FIFO_EN
  logic f_full, f_empty, f_pop;

  req_fifo #(
    .W($bits(call_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(req.req_valid && req.req_ready),
    .din(in_call),
    .pop(f_pop),
    .dout(cand),
    .full(f_full),
    .empty(f_empty)
  );

  assign cand_vld = !f_empty;
`else
  assign cand = in_call;
  assign cand_vld = req.req_valid;
`endif

  logic cand_bad, cand_up, cand_room;
  logic free0, free1, acc_slot;
  logic take, acc_fire;
  logic [FLOOR_W-1:0] cand_fl;
  pair_t cand_pair;

  assign cand_bad = !floor_ok(cand.src) ||
                    !floor_ok(cand.dst) ||
                    (cand.src == cand.dst);
  assign cand_up = (cand.dst > cand.src);
  assign cand_fl = cand_bad ? '0 : cand.src - 1'b1;
  assign cand_pair = hall_q[cand_up][cand_fl];
  assign free0 = (cand_pair[0] == EMPTY_FLOOR);
  assign free1 = (cand_pair[1] == EMPTY_FLOOR);
  assign acc_slot = !free0;
  // bad calls always have "room": they are consumed and dropped
  assign cand_room = cand_bad || free0 || free1;

`ifdef PQ_REQ_FIFO_EN
  assign req.req_ready = rst_n && !f_full;
  assign take = cand_vld && cand_room;
  assign f_pop = take;
`else
  assign req.req_ready = rst_n && cand_room;
  assign take = cand_vld && req.req_ready;
`endif

  assign acc_fire = take && !cand_bad;
  assign err_d = take && cand_bad;

  logic [1:0][5:0] hold_v;
  logic [1:0][FLOOR_W-1:0] curr_v;
  logic [1:0] up_v, brd_ok;
  logic [1:0][FLOOR_W-1:0] brd_fl;

  assign hold_v = {hold_2, hold_1};
  assign curr_v = {curr_elevator_2, curr_elevator_1};
  assign up_v = {dir_elevator[0], dir_elevator[1]};

  always_comb begin
    brd_ok = '0;
    brd_fl = '0;
    for (int k = 0; k < 2; k++) begin
      brd_ok[k] = hold_v[k][HOLD_BOARD] &&
                  floor_ok(curr_v[k]);
      if (brd_ok[k]) brd_fl[k] = curr_v[k] - 1'b1;
    end
  end

  logic [FLOOR_W-1:0] pick;

  always_comb begin
    hall_d = hall_q;
    car_d = car_q;
    pick = EMPTY_FLOOR;
    // accept only targets a slot empty in hall_q, so it
    // can never collide with a slot being boarded
    if (acc_fire)
      hall_d[cand_up][cand_fl][acc_slot] = cand.dst;
    for (int k = 0; k < 2; k++) begin
      if (hold_v[k][HOLD_ALIGHT]) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (hold_v[k][HOLD_DROP+s])
            car_d[k][s] = EMPTY_FLOOR;
        end
      end
      for (int s = 0; s < SLOTS; s++) begin
        pick = hall_q[up_v[k]][brd_fl[k]][s];
        // a slot already cleared in hall_d was taken by car 1
        if (brd_ok[k] && hold_v[k][HOLD_PICK+s] &&
            pick != EMPTY_FLOOR &&
            hall_d[up_v[k]][brd_fl[k]][s] != EMPTY_FLOOR) begin
          if (car_d[k][0] == EMPTY_FLOOR) begin
            car_d[k][0] = pick;
            hall_d[up_v[k]][brd_fl[k]][s] = EMPTY_FLOOR;
          end else if (car_d[k][1] == EMPTY_FLOOR) begin
            car_d[k][1] = pick;
            hall_d[up_v[k]][brd_fl[k]][s] = EMPTY_FLOOR;
          end
        end
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < N_FLOORS; f++) begin
        for (int s = 0; s < SLOTS; s++) begin
          cnt_d = cnt_d +
            {4'd0, hall_d[d][f][s] != EMPTY_FLOOR};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_q <= '0;
      car_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      hall_q <= hall_d;
      car_q <= car_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    up_passenger = '0;
    down_passenger = '0;
    for (int f = 1; f <= N_FLOORS; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        up_passenger[up_bit(f, s)] =
          (hall_q[DIR_UP][f-1][s] != EMPTY_FLOOR);
        down_passenger[dn_bit(f, s)] =
          (hall_q[DIR_DN][f-1][s] != EMPTY_FLOOR);
      end
    end
  end

  assign boarding_1 = car_q[0];
  assign boarding_2 = car_q[1];
  assign waiting_cnt = cnt_q;
  assign req.req_err = err_q;
endmodule

// File: tb/tb_passenger_queue.sv
// tb_passenger_queue: directed + random bench for
// passenger_queue against a behavioural model.
module tb_passenger_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] curr_elevator_1, curr_elevator_2;
  logic [1:0] dir_elevator;
  logic [5:0] hold_1, hold_2;
  logic [13:0] up_passenger, down_passenger;
  logic [5:0] boarding_1, boarding_2;
  logic [4:0] waiting_cnt;

  passenger_queue_if rq();

  passenger_queue dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(rq),
    .curr_elevator_1(curr_elevator_1),
    .curr_elevator_2(curr_elevator_2),
    .dir_elevator(dir_elevator),
    .hold_1(hold_1),
    .hold_2(hold_2),
    .up_passenger(up_passenger),
    .down_passenger(down_passenger),
    .boarding_1(boarding_1),
    .boarding_2(boarding_2),
    .waiting_cnt(waiting_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: mh[dir 1=up][floor 1..7][slot], mc[car][slot]
  int mh[2][8][2];
  int mc[2][2];
  bit merr;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  function automatic bit call_bad(int s, int d);
    return s < 1 || s > 7 || d < 1 || d > 7 || s == d;
  endfunction

  task automatic model_clear();
    foreach (mh[a, b, c]) mh[a][b][c] = 0;
    foreach (mc[a, b]) mc[a][b] = 0;
    merr = 0;
  endtask

  function automatic bit m_ready();
    int s = int'(rq.req_src);
    int d = int'(rq.req_dst);
    int u;
    if (!rst_n) return 1'b0;
    if (call_bad(s, d)) return 1'b1;
    u = (d > s) ? 1 : 0;
    return mh[u][s][0] == 0 || mh[u][s][1] == 0;
  endfunction

  task automatic model_step();
    int nh[2][8][2];
    int s, d, u, v, fl, dr, slot;
    logic [5:0] h[2];
    if (!rst_n) begin
      model_clear();
      return;
    end
    nh = mh;
    merr = 0;
    s = int'(rq.req_src);
    d = int'(rq.req_dst);
    if (rq.req_valid) begin
      if (call_bad(s, d)) begin
        merr = 1;
      end else begin
        u = (d > s) ? 1 : 0;
        if (mh[u][s][0] == 0) nh[u][s][0] = d;
        else if (mh[u][s][1] == 0) nh[u][s][1] = d;
      end
    end
    h[0] = hold_1;
    h[1] = hold_2;
    for (int k = 0; k < 2; k++) begin
      fl = (k == 0) ? int'(curr_elevator_1)
                    : int'(curr_elevator_2);
      dr = (k == 0) ? int'(dir_elevator[1])
                    : int'(dir_elevator[0]);
      if (h[k][5]) begin
        for (int i = 0; i < 2; i++)
          if (h[k][3+i]) mc[k][i] = 0;
      end
      if (h[k][2] && fl >= 1 && fl <= 7) begin
        for (int i = 0; i < 2; i++) begin
          if (h[k][i] && mh[dr][fl][i] != 0 &&
              nh[dr][fl][i] != 0) begin
            v = mh[dr][fl][i];
            slot = (mc[k][0] == 0) ? 0 :
                   (mc[k][1] == 0) ? 1 : -1;
            if (slot >= 0) begin
              mc[k][slot] = v;
              nh[dr][fl][i] = 0;
            end
          end
        end
      end
    end
    mh = nh;
  endtask

  function automatic logic [13:0] exp_up();
    logic [13:0] r = '0;
    for (int f = 1; f <= 7; f++)
      for (int s = 0; s < 2; s++)
        r[2*(f-1)+s] = (mh[1][f][s] != 0);
    return r;
  endfunction

  function automatic logic [13:0] exp_dn();
    logic [13:0] r = '0;
    for (int f = 1; f <= 7; f++)
      for (int s = 0; s < 2; s++)
        r[13-2*(f-1)-(1-s)] = (mh[0][f][s] != 0);
    return r;
  endfunction

  function automatic logic [5:0] exp_car(int k);
    return {3'(mc[k][1]), 3'(mc[k][0])};
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    foreach (mh[a, b, c]) if (mh[a][b][c] != 0) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    chk("ready", rq.req_ready, m_ready());
    chk("up", up_passenger, exp_up());
    chk("down", down_passenger, exp_dn());
    chk("board1", boarding_1, exp_car(0));
    chk("board2", boarding_2, exp_car(1));
    chk("count", waiting_cnt, exp_cnt());
    chk("err", rq.req_err, merr);
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic drive(
    input logic v,
    input logic [2:0] s, d, c1, c2,
    input logic [1:0] dr,
    input logic [5:0] h1, h2
  );
    rq.req_valid = v;
    rq.req_src = s;
    rq.req_dst = d;
    curr_elevator_1 = c1;
    curr_elevator_2 = c2;
    dir_elevator = dr;
    hold_1 = h1;
    hold_2 = h2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 2'b00, 6'd0, 6'd0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ready"}, rq.req_ready, 0);
    chk({tag, "_up"}, up_passenger, 0);
    chk({tag, "_dn"}, down_passenger, 0);
    chk({tag, "_b1"}, boarding_1, 0);
    chk({tag, "_b2"}, boarding_2, 0);
    chk({tag, "_cnt"}, waiting_cnt, 0);
  endtask

  initial begin
    model_clear();
    idle();
    repeat (3) tick();
    chk_zero("rst");
    rst_n = 1'b1;

    drive(1, 2, 5, 0, 0, 2'b00, 6'd0, 6'd0);
    #1 chk("call_ready", rq.req_ready, 1);
    tick();
    idle();
    chk("call_up2", up_passenger[2], 1);
    chk("call_cnt", waiting_cnt, 1);

    drive(1, 3, 1, 0, 0, 2'b00, 6'd0, 6'd0);
    tick();
    tick();
    #1 chk("full_ready", rq.req_ready, 0);
    chk("full_dn", down_passenger[9:8], 2'b11);
    tick();
    idle();
    chk("full_cnt", waiting_cnt, 3);

    drive(0, 0, 0, 2, 0, 2'b10, 6'b000101, 6'd0);
    tick();
    idle();
    chk("brd_b1", boarding_1, 6'b000101);
    chk("brd_up2", up_passenger[2], 0);
    chk("brd_cnt", waiting_cnt, 2);

    drive(1, 2, 6, 0, 0, 2'b00, 6'd0, 6'd0);
    tick();
    drive(0, 0, 0, 2, 0, 2'b10, 6'b000101, 6'd0);
    tick();
    idle();
    chk("fill_b1", boarding_1, 6'b110101);
    drive(1, 5, 7, 0, 0, 2'b00, 6'd0, 6'd0);
    tick();
    drive(0, 0, 0, 5, 0, 2'b10, 6'b101101, 6'd0);
    tick();
    idle();
    chk("swap_b1", boarding_1, 6'b110111);
    chk("swap_cnt", waiting_cnt, 2);

    drive(1, 4, 6, 0, 0, 2'b00, 6'd0, 6'd0);
    tick();
    drive(0, 0, 0, 4, 4, 2'b11,
          6'b111101, 6'b000101);
    tick();
    idle();
    chk("both_b1", boarding_1, 6'b000110);
    chk("both_b2", boarding_2, 6'b000000);
    chk("both_cnt", waiting_cnt, 2);

    drive(1, 0, 3, 0, 0, 2'b00, 6'd0, 6'd0);
    #1 chk("bad0_ready", rq.req_ready, 1);
    tick();
    chk("bad0_err", rq.req_err, 1);
    drive(1, 4, 4, 0, 0, 2'b00, 6'd0, 6'd0);
    tick();
    idle();
    chk("bad1_err", rq.req_err, 1);
    chk("bad1_cnt", waiting_cnt, 2);
    tick();
    chk("bad_clr", rq.req_err, 0);

    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)),
            2'($urandom),
            6'($urandom),
            6'($urandom));
      if (i == 300) begin
        #1 rst_n = 1'b0;
        model_clear();
        #1 chk_zero("midrst");
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/passenger_queue.md
Name: passenger_queue

Overview:
- Source/sink end of the passenger interface consumed by the turn/hold decision logic.
- Accepts hall-call requests (source floor, destination floor) and stores each waiting passenger's destination in per-floor, per-direction slots.
- Publishes the up_passenger/down_passenger occupancy vectors.
- Executes hold commands from the decision logic: drops arrived riders, boards waiting riders, and publishes boarding_1/boarding_2.

Parameters:
- N_FLOORS, 7, floor count; floors encoded 1..7, 0 = empty slot (fixed by 14-bit vectors).
- FIFO_DEPTH, 4, request FIFO entries (used only with PQ_REQ_FIFO_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  new hall call present
- req_src  in  3  call floor
- req_dst  in  3  destination floor
- req_ready  out  1  call accepted this cycle when req_valid&&req_ready
- req_err  out  1  one-cycle pulse: invalid call dropped
- curr_elevator_1, curr_elevator_2  in  3  current floor of car 1 / car 2
- dir_elevator  in  2  [1]=car 1 up, [0]=car 2 up
- hold_1, hold_2  in  6  [5] alight enable, [4:3] alighting slots, [2] board enable, [1:0] boarding slots
- up_passenger  out  14  up-call occupancy, floor f slot s at bit 2(f-1)+s
- down_passenger  out  14  down-call occupancy, floor f slot s at bit 13-2(f-1)-(1-s), i.e. floor 1 at [13:12]
- boarding_1, boarding_2  out  6  car riders' destinations, [5:3] slot 1, [2:0] slot 0, 0 = empty
- waiting_cnt  out  5  total occupied hall slots (0..28)

Behaviour:
- Reset (async, rst_n low): all hall slots, boarding_1/2, waiting_cnt = 0; req_ready = 0 while in reset; req_err = 0. Reset mid-operation drops all passengers.
- Storage: dest[dir][floor][slot], 3 bits each. Occupancy bit = (dest != 0). Outputs are registered state, valid the cycle after the update.
- Call validation: invalid if src or dst is 0 or >7, or src == dst.
  - Invalid call: req_ready = 1, dropped, req_err pulses the next cycle.
  - Direction = up when dst > src, else down.
- req_ready (combinational from current registers) = 1 iff the target floor/direction has a free slot.
- Accept: write dst into the lowest free slot (slot 0 before slot 1). A slot freed by boarding in cycle N is allocatable from N+1.
- Boarding/alighting, per car k, in one clock edge:
  - Alighting: if hold_k[5], clear each boarding_k slot whose hold_k[4:3] bit is set.
  - Boarding: if hold_k[2], each hold_k[1:0] slot s at floor curr_elevator_k, direction dir_elevator bit, moves its stored destination into a free car slot.
  - Free car slots are evaluated after the same-cycle alighting clear. Car slot 0 is filled first. The hall slot is cleared.
  - If no car slot is free, the rider stays waiting; this is not an error.
  - hold bits naming an empty hall slot are ignored.
- Conflicts:
  - Both cars boarding the same floor, direction and slot: car 1 wins; car 2 ignores that slot.
  - Call accept and boarding in the same cycle on the same floor/direction: the accept uses the pre-board free slot. Never allocate a slot that is occupied at the clock edge.
  - curr_elevator_k == 0 or >7: hold_k[2] ignored.
- waiting_cnt: registered popcount of all hall occupancy bits. Saturation is impossible (28 max).

Optional Feature:
- PQ_REQ_FIFO_EN defined:
  - A FIFO_DEPTH-entry request FIFO sits in front of the validator.
  - req_ready = FIFO not full.
  - The head retries allocation every cycle until its floor/direction slot frees; strict order, head blocks the rest.
  - Invalid heads are popped with req_err.
  - Reset empties the FIFO.
- PQ_REQ_FIFO_EN undefined: direct path as above, zero buffering.

Decomposition:
- Package passenger_pkg: N_FLOORS, SLOTS=2, FLOOR_W=3, EMPTY_FLOOR=3'd0, hold field bit-index constants (HOLD_ALIGHT=5, HOLD_BOARD=2), and occupancy-bit index functions for the up and down layouts.
- Sub-module req_fifo: a generic sync FIFO, instantiated only under PQ_REQ_FIFO_EN.

Test Plan:
- Reset, then call src=2 dst=5 → next cycle up_passenger bit 2 = 1, waiting_cnt=1, req_ready stayed 1.
- Three calls src=3 dst=1 → first two accepted (down_passenger[9:8]=2'b11), third sees req_ready=0; with PQ_REQ_FIFO_EN it queues and lands after a board clears a slot.
- Car 1 at floor 2, dir up, hold_1=6'b000_1_01 with a waiting rider dst=5 → boarding_1=6'b000_101, up_passenger bit 2 cleared, waiting_cnt decrements.
- Car 1 full {6,5} at floor 5, hold_1=6'b1_01_1_01 with a floor-5 up rider dst=7 → slot 0 alights and rider boards same cycle, boarding_1=6'b110_111.
- Both cars at floor 4 up, both hold board slot 0 → car 1 gets the rider; boarding_2 unchanged.
- Calls src=0 dst=3 and src=4 dst=4 → req_err pulses twice, no state change; assert rst_n low mid-traffic → all outputs 0 asynchronously.
